frog_hop_ctrl: RTL
==================

FROG_HOP_CTRL -- requirements
Module: frog_hop_ctrl

Interface
REQ-001 Parameter HOP_TICKS, default 8, number of movement ticks per hop (range 1..255).
REQ-002 Parameter REPEAT_DELAY, default 16, ticks a key is held after a hop before the next hop auto-starts (range 1..255).
REQ-003 CLK  input  1  system clock.
REQ-004 RESETn  input  1  reset, asynchronous, active-low.
REQ-005 tick  input  1  one-CLK movement strobe; the same strobe drives the downstream frog_move timer_done.
REQ-006 key_up, key_down, key_left, key_right  input  1 each  raw key levels from the keyboard decoder; asynchronous to CLK; 1 = pressed.
REQ-007 freeze  input  1  level; 1 = frog dead or paused, all motion inhibited.
REQ-008 up, down, left, right  output  1 each  registered motion levels feeding frog_move; at most one is high at any time.
REQ-009 busy  output  1  registered; high while a hop is in progress.
REQ-010 hop_done  output  1  registered one-CLK pulse marking the end of a hop (score hook).

Function
REQ-011 Each key passes through a 2-flop synchroniser, then a rising-edge detector; latency from key edge to an internal press event is 3 CLK.
REQ-012 Press event latches a pending direction; if several press events occur in one CLK, priority is up > down > left > right; a later press overwrites an unconsumed pending direction.
REQ-013 State machine: IDLE, HOP, HOLD; state, the hop counter and all outputs change only on CLK edges where tick=1, except for freeze and reset.
REQ-014 IDLE: on tick with pending valid -> HOP; dir := pending; pending cleared; hop_cnt := HOP_TICKS-1; busy := 1.
REQ-015 HOP: exactly one output, matching dir, is high; on each tick, if hop_cnt != 0 then decrement.
REQ-016 HOP, tick with hop_cnt == 0: output deasserts; hop_done pulses on the next CLK edge only; if the synchronised key for dir is still held -> HOLD with rep_cnt := REPEAT_DELAY-1, else -> IDLE; busy := 0 in both cases.
REQ-017 HOLD: outputs low; on tick, if the synchronised key for dir is released -> IDLE; else if rep_cnt == 0 -> HOP with the same dir and hop_cnt := HOP_TICKS-1; else decrement rep_cnt.
REQ-018 HOLD: a pending press for another direction takes precedence on the next tick and starts a HOP in that direction, as in IDLE.
REQ-019 Presses arriving during HOP are latched as pending and start the next hop on the first tick after the hop ends (no lost input, no interleaving).
REQ-020 freeze=1: on the next CLK edge, regardless of tick, the block enters IDLE, clears pending, deasserts all outputs, and suppresses hop_done; press events are ignored while freeze=1.
REQ-021 Result: frog displacement per hop = HOP_TICKS ticks x downstream speed; one tick of latency between a state change and the downstream update.

Reset
REQ-022 RESETn low: state=IDLE, pending cleared, dir=NONE, counters=0, synchroniser and edge flops=0, and all outputs (up, down, left, right, busy, hop_done) = 0.
REQ-023 Reset mid-hop aborts the hop immediately; no hop_done is generated.

Configuration
REQ-024 Macro FROG_AUTOREPEAT_EN defined: HOLD state and REPEAT_DELAY are in effect as specified above.
REQ-025 FROG_AUTOREPEAT_EN undefined: HOLD is not built; HOP always ends in IDLE; holding a key produces exactly one hop; a new press edge is required for the next hop.

Structure
REQ-026 Shared package frog_pkg: dir_t enum (DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT), hop_state_t enum (IDLE, HOP, HOLD), and constants HOP_TICKS_DEF=8 and REPEAT_DELAY_DEF=16.
REQ-027 Sub-module key_sync_edge (2-flop synchroniser + rising-edge pulse, also exports the synchronised level) is instantiated once per key; everything else resides in frog_hop_ctrl.

Verification (HOP_TICKS=8, REPEAT_DELAY=16, tick every 10 CLK)
REQ-028 Single tap of key_up held 5 CLK -> up high for exactly 8 ticks, then low; one hop_done pulse; busy high for the same interval.
REQ-029 key_left and key_right rise on the same CLK -> only left hops; right is never asserted.
REQ-030 key_down pressed during tick 3 of an up hop -> up completes all 8 ticks, then down runs 8 ticks starting on the first tick after the hop ends; no overlap.
REQ-031 key_right held for 60 ticks with FROG_AUTOREPEAT_EN -> hop 8 ticks, gap 16 ticks, hop 8 ticks, and so on; without the macro -> exactly one 8-tick hop.
REQ-032 freeze asserted at tick 4 of a hop -> all outputs low on the next CLK, no hop_done; a press during freeze is ignored after freeze drops.
REQ-033 RESETn pulsed low mid-hop asynchronously -> all outputs 0 immediately; the next press starts a clean 8-tick hop.

Source files
------------

// File: rtl/frog_pkg.sv
// Shared types and defaults for the frog hop controller.
// Key vectors are ordered {right, left, down, up}.
package frog_pkg;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        HOP,
        HOLD
    } hop_state_t;

    localparam int HOP_TICKS_DEF    = 8;
    localparam int REPEAT_DELAY_DEF = 16;

    function automatic logic [3:0] dir_onehot(input dir_t d);
        logic [3:0] oh;
        oh = 4'b0000;
        case (d)
            DIR_UP:    oh = 4'b0001;
            DIR_DOWN:  oh = 4'b0010;
            DIR_LEFT:  oh = 4'b0100;
            DIR_RIGHT: oh = 4'b1000;
            default:   oh = 4'b0000;
        endcase
        return oh;
    endfunction

    function automatic logic key_held(input dir_t d, input logic [3:0] lvl);
        return |(dir_onehot(d) & lvl);
    endfunction

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchroniser for one raw key level plus a rising-edge pulse.
// The synchronised level is exported for hold detection.
module key_sync_edge
    import frog_pkg::*;
(
    input  logic CLK,
    input  logic RESETn,
    input  logic key_i,
    output logic level_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= key_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/frog_hop_ctrl.sv
// Frog hop sequencer: key presses become tick-timed motion levels.
// Define FROG_AUTOREPEAT_EN to build the HOLD/auto-repeat path.
module frog_hop_ctrl
    import frog_pkg::*;
#(
    parameter int HOP_TICKS    = HOP_TICKS_DEF,
    parameter int REPEAT_DELAY = REPEAT_DELAY_DEF
) (
    input  logic CLK,
    input  logic RESETn,
    input  logic tick,
    input  logic key_up,
    input  logic key_down,
    input  logic key_left,
    input  logic key_right,
    input  logic freeze,
    output logic up,
    output logic down,
    output logic left,
    output logic right,
    output logic busy,
    output logic hop_done
);

    localparam logic [7:0] HOP_LAST = 8'(HOP_TICKS - 1);

    logic [3:0] keys;
    logic [3:0] lvl;
    logic [3:0] rise;
    dir_t       press_dir;

    hop_state_t state_q, state_d;
    dir_t       dir_q, dir_d;
    dir_t       pend_q, pend_d;
    logic [7:0] hop_cnt_q, hop_cnt_d;
    logic [3:0] out_q, out_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    assign keys = {key_right, key_left, key_down, key_up};

    for (genvar i = 0; i < 4; i++) begin : g_key
        key_sync_edge u_sync (
            .CLK     (CLK),
            .RESETn  (RESETn),
            .key_i   (keys[i]),
            .level_o (lvl[i]),
            .rise_o  (rise[i])
        );
    end

`ifdef FROG_AUTOREPEAT_EN
    localparam logic [7:0] REP_LAST = 8'(REPEAT_DELAY - 1);
    logic [7:0] rep_cnt_q, rep_cnt_d;
    logic       held;
    assign held = key_held(dir_q, lvl);
`else
    logic unused_cfg;
    assign unused_cfg = ^{lvl, 8'(REPEAT_DELAY)};
`endif

    always_comb begin
        press_dir = DIR_NONE;
        if (freeze)       press_dir = DIR_NONE;
        else if (rise[0]) press_dir = DIR_UP;
        else if (rise[1]) press_dir = DIR_DOWN;
        else if (rise[2]) press_dir = DIR_LEFT;
        else if (rise[3]) press_dir = DIR_RIGHT;
    end

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        pend_d    = pend_q;
        hop_cnt_d = hop_cnt_q;
        done_d    = 1'b0;
`ifdef FROG_AUTOREPEAT_EN
        rep_cnt_d = rep_cnt_q;
`endif
        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (pend_q != DIR_NONE) begin
                        state_d   = HOP;
                        dir_d     = pend_q;
                        pend_d    = DIR_NONE;
                        hop_cnt_d = HOP_LAST;
                    end
                end
                HOP: begin
                    if (hop_cnt_q != 8'd0) begin
                        hop_cnt_d = hop_cnt_q - 8'd1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                        dir_d   = DIR_NONE;
`ifdef FROG_AUTOREPEAT_EN
                        if (held) begin
                            state_d   = HOLD;
                            dir_d     = dir_q;
                            rep_cnt_d = REP_LAST;
                        end
`endif
                    end
                end
`ifdef FROG_AUTOREPEAT_EN
                HOLD: begin
                    // A fresh press beats repeating the held direction
                    if (pend_q != DIR_NONE) begin
                        state_d   = HOP;
                        dir_d     = pend_q;
                        pend_d    = DIR_NONE;
                        hop_cnt_d = HOP_LAST;
                    end else if (!held) begin
                        state_d = IDLE;
                        dir_d   = DIR_NONE;
                    end else if (rep_cnt_q == 8'd0) begin
                        state_d   = HOP;
                        hop_cnt_d = HOP_LAST;
                    end else begin
                        rep_cnt_d = rep_cnt_q - 8'd1;
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                    dir_d   = DIR_NONE;
                end
            endcase
        end
        if (press_dir != DIR_NONE) pend_d = press_dir;
        if (freeze) begin
            state_d = IDLE;
            dir_d   = DIR_NONE;
            pend_d  = DIR_NONE;
            done_d  = 1'b0;
        end
    end

    always_comb begin
        busy_d = (state_d == HOP);
        out_d  = busy_d ? dir_onehot(dir_d) : 4'b0000;
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q   <= IDLE;
            dir_q     <= DIR_NONE;
            pend_q    <= DIR_NONE;
            hop_cnt_q <= 8'd0;
            out_q     <= 4'b0000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            pend_q    <= pend_d;
            hop_cnt_q <= hop_cnt_d;
            out_q     <= out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

`ifdef FROG_AUTOREPEAT_EN
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) rep_cnt_q <= 8'd0;
        else         rep_cnt_q <= rep_cnt_d;
    end
`endif

    assign {right, left, down, up} = out_q;
    assign busy     = busy_q;
    assign hop_done = done_q;

endmodule
